// File: rtl/fma_pkg.sv
// Purpose: shared constants, S1 payload type and the 4-bit LZC cell for the FMA normalizer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package fma_pkg;

    localparam int WIDTH = 106;  // 2 x 53-bit significand product
    localparam int EXP_W = 13;   // unbiased two's-complement exponent with guard bits
    localparam int LZC_W = 7;    // clog2(WIDTH+1)

    // Stage-1 register payload.
    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic [EXP_W-1:0] exp;
        logic             sticky;
        logic [LZC_W-1:0] lzc;
    } s1_t;

    // Leading zeros of a nibble. An all-zero nibble returns 3; the tree uses
    // the separate valid (any-bit-set) flag to skip such nibbles.
    function automatic logic [1:0] lzc4(input logic [3:0] d);
        logic [1:0] c;
        casez (d)
            4'b1???: c = 2'd0;
            4'b01??: c = 2'd1;
            4'b001?: c = 2'd2;
            default: c = 2'd3;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fma_lzc.sv
// Purpose: combinational leading-zero counter over the WIDTH-bit adder sum.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: data (WIDTH) in, lzc (LZC_W) out; lzc = WIDTH for an all-zero input.
module fma_lzc
    import fma_pkg::*;
(
    input  logic [WIDTH-1:0] data,
    output logic [LZC_W-1:0] lzc
);

    // Pad to a power-of-two number of nibbles. The pad is ones, so an all-zero
    // data word counts exactly WIDTH zeros and the root is always valid.
    localparam int PAD_W      = 128;
    localparam int NODES      = (PAD_W / 4) * 2 - 1;
    localparam int FIRST_LEAF = (PAD_W / 4) - 1;

    logic [PAD_W-1:0] padded;
    assign padded = {data, {(PAD_W - WIDTH){1'b1}}};

    // Heap-ordered binary tree: node n has children 2n+1 (MSB side) and 2n+2.
    logic [LZC_W-1:0] node_cnt [NODES];
    logic             node_vld [NODES];

    for (genvar n = 0; n < NODES; n++) begin : g_node
        if (n >= FIRST_LEAF) begin : g_leaf
            localparam int LSB = PAD_W - 4 * (n - FIRST_LEAF + 1);
            assign node_vld[n] = |padded[LSB +: 4];
            assign node_cnt[n] = LZC_W'(lzc4(padded[LSB +: 4]));
        end else begin : g_merge
            // Bit span covered by each child of this node.
            localparam int CHILD_SPAN = PAD_W >> $clog2(n + 2);
            assign node_vld[n] = node_vld[2*n+1] | node_vld[2*n+2];
            assign node_cnt[n] = node_vld[2*n+1] ? node_cnt[2*n+1]
                                                 : LZC_W'(CHILD_SPAN) + node_cnt[2*n+2];
        end
    end

    // The root is valid by construction; the fallback only keeps the
    // all-zero meaning explicit.
    assign lzc = node_vld[0] ? node_cnt[0] : LZC_W'(WIDTH);

endmodule

// File: rtl/fma_normalizer.sv
// Purpose: two-stage post-addition normalizer (LZC in S1, carry/zero/shift select in S2).
// Latency: 2 cycles input transfer to out_valid; one result per cycle sustained.
// Backpressure: each stage holds when the next is full and stalled; in_ready = !s1_valid | s2_adv.
// Ports: in_valid/in_ready with in_sum, in_cout, in_exp, in_sticky;
//        out_valid/out_ready with out_mant, out_exp, out_sticky, out_zero.
module fma_normalizer
    import fma_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_cout,
    input  logic [EXP_W-1:0] in_exp,
    input  logic             in_sticky,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mant,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_sticky,
    output logic             out_zero
);

    logic             s1_valid;
    s1_t              s1_q;
    logic             s2_adv;
    logic [LZC_W-1:0] in_lzc;

    fma_lzc u_lzc (
        .data (in_sum),
        .lzc  (in_lzc)
    );

    // out_valid is the S2 valid flag.
    assign s2_adv   = !out_valid | out_ready;
    assign in_ready = !s1_valid | s2_adv;

    // ---------------- Stage 1 ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q <= '{sum: in_sum, cout: in_cout, exp: in_exp,
                          sticky: in_sticky, lzc: in_lzc};
            end
        end
    end

    // ---------------- Stage 2 datapath ----------------
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] nxt_mant;
    logic [EXP_W-1:0] nxt_exp;
    logic             nxt_sticky;
    logic             nxt_zero;

    always_comb begin
        // Log-depth barrel shifter: one conditional stage per lzc bit.
        shifted = s1_q.sum;
        for (int k = 0; k < LZC_W; k++) begin
            if (s1_q.lzc[k]) begin
                shifted = shifted << (1 << k);
            end
        end

        nxt_mant   = shifted;
        nxt_exp    = s1_q.exp - EXP_W'(s1_q.lzc);   // wraps; range check is downstream
        nxt_sticky = s1_q.sticky;
        nxt_zero   = 1'b0;

        if (s1_q.cout) begin
            // Carry-out: shift right by one, the dropped LSB joins the sticky.
            nxt_mant   = {1'b1, s1_q.sum[WIDTH-1:1]};
            nxt_exp    = s1_q.exp + EXP_W'(1);
            nxt_sticky = s1_q.sticky | s1_q.sum[0];
        end else if (s1_q.sum == '0) begin
            nxt_mant = '0;
            nxt_exp  = '0;
            nxt_zero = 1'b1;
        end
    end

    // ---------------- Stage 2 registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_mant   <= '0;
            out_exp    <= '0;
            out_sticky <= 1'b0;
            out_zero   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_mant   <= nxt_mant;
                out_exp    <= nxt_exp;
                out_sticky <= nxt_sticky;
                out_zero   <= nxt_zero;
            end
        end
    end

endmodule

// File: tb/tb_fma_normalizer.sv
module tb_fma_normalizer;
    import fma_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum;
    logic             in_cout;
    logic [EXP_W-1:0] in_exp;
    logic             in_sticky;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_mant;
    logic [EXP_W-1:0] out_exp;
    logic             out_sticky;
    logic             out_zero;

    int tests = 0;
    int fails = 0;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    fma_normalizer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_cout    (in_cout),
        .in_exp     (in_exp),
        .in_sticky  (in_sticky),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mant   (out_mant),
        .out_exp    (out_exp),
        .out_sticky (out_sticky),
        .out_zero   (out_zero)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [WIDTH-1:0] s, input logic c,
                         input logic [EXP_W-1:0] e, input logic st);
        in_valid  = 1'b1;
        in_sum    = s;
        in_cout   = c;
        in_exp    = e;
        in_sticky = st;
    endtask

    // Issue one beat with out_ready high; returns at the negedge where it sits in S2.
    task automatic issue(input logic [WIDTH-1:0] s, input logic c,
                         input logic [EXP_W-1:0] e, input logic st);
        @(negedge clk);
        out_ready = 1'b1;
        drive(s, c, e, st);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_cout = 1'b0;
        in_exp = '0; in_sticky = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || out_mant !== '0 || out_exp !== '0 ||
            out_sticky !== 1'b0 || out_zero !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b m=%h e=%h s=%b z=%b want all zero",
                     out_valid, out_mant, out_exp, out_sticky, out_zero);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_msb;
        @(negedge clk);
        drive(ONE << 105, 1'b0, 13'd10, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL msb_latency1: got out_valid=%b want 0", out_valid);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_mant !== (ONE << 105) || out_exp !== 13'd10 ||
            out_zero !== 1'b0 || out_sticky !== 1'b0) begin
            fails++;
            $display("FAIL msb_set: got v=%b m=%h e=%h s=%b z=%b want v=1 m=%h e=00a s=0 z=0",
                     out_valid, out_mant, out_exp, out_sticky, out_zero, ONE << 105);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL msb_drain: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_lsb;
        issue(ONE, 1'b0, 13'd0, 1'b1);
        tests++;
        if (out_valid !== 1'b1 || out_mant !== (ONE << 105) || out_exp !== 13'(-105) ||
            out_sticky !== 1'b1 || out_zero !== 1'b0) begin
            fails++;
            $display("FAIL lsb_only: got v=%b m=%h e=%h s=%b z=%b want v=1 m=%h e=%h s=1 z=0",
                     out_valid, out_mant, out_exp, out_sticky, out_zero, ONE << 105, 13'(-105));
        end
    endtask

    task automatic test_carry;
        issue(ONE, 1'b1, 13'd5, 1'b0);
        tests++;
        if (out_mant !== (ONE << 105) || out_exp !== 13'd6 ||
            out_sticky !== 1'b1 || out_zero !== 1'b0) begin
            fails++;
            $display("FAIL carry_drop: got m=%h e=%h s=%b z=%b want m=%h e=006 s=1 z=0",
                     out_mant, out_exp, out_sticky, out_zero, ONE << 105);
        end
        // Carry at the top of the exponent range wraps without saturation.
        issue((ONE << 105) | (ONE << 2), 1'b1, 13'h0fff, 1'b0);
        tests++;
        if (out_mant !== ((ONE << 105) | (ONE << 104) | (ONE << 1)) ||
            out_exp !== 13'h1000 || out_sticky !== 1'b0) begin
            fails++;
            $display("FAIL carry_wrap: got m=%h e=%h s=%b want m=%h e=1000 s=0",
                     out_mant, out_exp, out_sticky, (ONE << 105) | (ONE << 104) | (ONE << 1));
        end
    endtask

    task automatic test_zero;
        issue('0, 1'b0, 13'd77, 1'b1);
        tests++;
        if (out_zero !== 1'b1 || out_mant !== '0 || out_exp !== '0 || out_sticky !== 1'b1) begin
            fails++;
            $display("FAIL zero: got m=%h e=%h s=%b z=%b want m=0 e=0 s=1 z=1",
                     out_mant, out_exp, out_sticky, out_zero);
        end
    endtask

    task automatic test_shift;
        // Bits 51,50 set: 54 leading zeros.
        issue(ONE << 51 | ONE << 50, 1'b0, 13'd3, 1'b0);
        tests++;
        if (out_mant !== ((ONE << 105) | (ONE << 104)) || out_exp !== 13'(-51)) begin
            fails++;
            $display("FAIL shift_mid: got m=%h e=%h want m=%h e=%h",
                     out_mant, out_exp, (ONE << 105) | (ONE << 104), 13'(-51));
        end
        // Exponent underflow wraps: -4096 - 105.
        issue(ONE, 1'b0, 13'h1000, 1'b0);
        tests++;
        if (out_mant !== (ONE << 105) || out_exp !== 13'hf97) begin
            fails++;
            $display("FAIL shift_wrap: got m=%h e=%h want m=%h e=0f97",
                     out_mant, out_exp, ONE << 105);
        end
    endtask

    task automatic test_back_to_back;
        logic [WIDTH-1:0] s [4];
        logic             c [4];
        logic [EXP_W-1:0] e [4];
        logic [WIDTH-1:0] wm [4];
        logic [EXP_W-1:0] we [4];
        logic             ws [4];
        s[0] = ONE << 105;          c[0] = 1'b0; e[0] = 13'd0;
        wm[0] = ONE << 105;         we[0] = 13'd0;     ws[0] = 1'b0;
        s[1] = ONE << 100;          c[1] = 1'b0; e[1] = 13'd20;
        wm[1] = ONE << 105;         we[1] = 13'd15;    ws[1] = 1'b0;
        s[2] = ONE << 3;            c[2] = 1'b0; e[2] = 13'd0;
        wm[2] = ONE << 105;         we[2] = 13'(-102); ws[2] = 1'b0;
        s[3] = (ONE << 105) | ONE;  c[3] = 1'b1; e[3] = 13'd7;
        wm[3] = (ONE << 105) | (ONE << 104); we[3] = 13'd8; ws[3] = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 7; cyc++) begin
            @(negedge clk);
            if (cyc >= 2 && cyc < 6) begin
                tests++;
                if (out_valid !== 1'b1 || out_mant !== wm[cyc-2] ||
                    out_exp !== we[cyc-2] || out_sticky !== ws[cyc-2]) begin
                    fails++;
                    $display("FAIL b2b_beat%0d: got v=%b m=%h e=%h s=%b want v=1 m=%h e=%h s=%b",
                             cyc - 2, out_valid, out_mant, out_exp, out_sticky,
                             wm[cyc-2], we[cyc-2], ws[cyc-2]);
                end
            end
            if (in_ready !== 1'b1) begin
                tests++;
                fails++;
                $display("FAIL b2b_in_ready: got %b want 1 at cycle %0d", in_ready, cyc);
            end
            if (cyc < 4) drive(s[cyc], c[cyc], e[cyc], 1'b0);
            else         in_valid = 1'b0;
        end
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_drain: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure;
        // A: bits 92,90 -> lzc 13; B: bits 51,50 -> lzc 54; C: carry on zero sum.
        logic [WIDTH-1:0] am;
        am = (ONE << 105) | (ONE << 103);
        @(negedge clk);
        out_ready = 1'b0;
        drive(ONE << 92 | ONE << 90, 1'b0, 13'd20, 1'b0);
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_ready_one_held: got %b want 1", in_ready);
        end
        drive(ONE << 51 | ONE << 50, 1'b0, 13'd100, 1'b0);
        @(negedge clk);
        drive('0, 1'b1, 13'd2, 1'b0);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_mant !== am || out_exp !== 13'd7) begin
                fails++;
                $display("FAIL bp_hold%0d: got rdy=%b v=%b m=%h e=%h want rdy=0 v=1 m=%h e=007",
                         k, in_ready, out_valid, out_mant, out_exp, am);
            end
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_mant !== ((ONE << 105) | (ONE << 104)) || out_exp !== 13'd46) begin
            fails++;
            $display("FAIL bp_out_B: got v=%b m=%h e=%h want v=1 m=%h e=02e",
                     out_valid, out_mant, out_exp, (ONE << 105) | (ONE << 104));
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_mant !== (ONE << 105) || out_exp !== 13'd3 || out_zero !== 1'b0) begin
            fails++;
            $display("FAIL bp_out_C: got v=%b m=%h e=%h z=%b want v=1 m=%h e=003 z=0",
                     out_valid, out_mant, out_exp, out_zero, ONE << 105);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_drain: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_midflight;
        @(negedge clk);
        out_ready = 1'b0;
        drive(ONE << 10, 1'b0, 13'd1, 1'b1);
        @(negedge clk);
        drive(ONE << 20, 1'b0, 13'd2, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_setup: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_async: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                tests++;
                fails++;
                $display("FAIL rst_mid_stale%0d: got v=%b rdy=%b want v=0 rdy=1",
                         k, out_valid, in_ready);
            end
        end
        tests++;
        if (out_valid !== 1'b0 || out_mant !== '0) begin
            fails++;
            $display("FAIL rst_mid_clean: got v=%b m=%h want v=0 m=0", out_valid, out_mant);
        end
    endtask

    initial begin
        test_reset();
        test_msb();
        test_lsb();
        test_carry();
        test_zero();
        test_shift();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard bound so the run always ends even if a task stalls.
    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded 20000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fma_normalizer.md
# fma_normalizer

Two-stage pipelined post-addition normalizer for the FP fused multiply-add datapath. Consumes the raw 106-bit sum and carry-out of the wide mantissa adder, plus the pre-computed result exponent and alignment sticky. Produces a left-justified mantissa (MSB = 1 unless the result is zero), a corrected exponent and an updated sticky for the rounding stage. Valid/ready handshake on both sides; sustained throughput of one result per cycle.

## Interface
- `WIDTH`, 106: sum width (2 × 53-bit significand product).
- `EXP_W`, 13: exponent width; two's-complement, unbiased, with guard bits.
- `LZC_W`, 7: leading-zero-count width, equal to clog2(WIDTH+1).

- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: input beat valid.
- `in_ready` output 1: stage can accept an input beat.
- `in_sum` input WIDTH: adder sum `s`.
- `in_cout` input 1: adder carry-out `c_out`.
- `in_exp` input EXP_W: result exponent before normalization.
- `in_sticky` input 1: OR of all bits discarded during alignment.
- `out_valid` output 1: output beat valid.
- `out_ready` input 1: downstream accepts the output beat.
- `out_mant` output WIDTH: normalized mantissa.
- `out_exp` output EXP_W: adjusted exponent.
- `out_sticky` output 1: updated sticky.
- `out_zero` output 1: the result is exactly zero.

## Operation
**Stage 1 (S1)**
- Captures `in_sum`, `in_cout`, `in_exp` and `in_sticky`.
- Captures `lzc` = leading zeros of `in_sum`, computed by `fma_lzc`.
- `lzc` = WIDTH when `in_sum` = 0.

**Stage 2 (S2)** computes from the registered S1 values:
- **Carry case** (`cout` = 1):
  - `out_mant` = {1'b1, `sum`[WIDTH-1:1]}
  - `out_exp` = `exp` + 1
  - `out_sticky` = `sticky` | `sum`[0]
- **Zero case** (`cout` = 0 and `sum` = 0):
  - `out_mant` = 0, `out_exp` = 0, `out_zero` = 1
  - `out_sticky` = `sticky`
- **Otherwise**:
  - `out_mant` = `sum` << `lzc`
  - `out_exp` = `exp` − `lzc`, zero-extended `lzc`, two's-complement wrap, no saturation
  - `out_sticky` = `sticky`

**Exponent range**
- Exponent underflow or overflow is not detected here; the rounding stage owns range checks.

**Handshake**
- An input transfer occurs when `in_valid` & `in_ready`.
- An output transfer occurs when `out_valid` & `out_ready`.
- `in_ready` = !`s1_valid` | `s2_adv`, where `s2_adv` = !`s2_valid` | `out_ready`.
- S1 moves into S2 when `s1_valid` & `s2_adv`.
- A stalled register holds its data and valid unchanged.
- `out_*` must stay stable while `out_valid` & !`out_ready`.
- Simultaneous input and output transfers in the same cycle are allowed; the pipeline stays full and drops nothing.

## Timing
- Latency: 2 cycles from the input transfer to `out_valid`, with no backpressure.
- Throughput: 1 result per cycle while `out_ready` = 1.
- Buffering: up to 2 beats in flight. `in_ready` drops only when both stages are valid and `out_ready` = 0.
- Reset values: `s1_valid`, `s2_valid` and `out_valid` = 0; `out_mant`, `out_exp`, `out_sticky` and `out_zero` = 0; `in_ready` = 1 one cycle after reset deassertion (combinational from the cleared valids).
- Reset asserted mid-operation: all in-flight beats are discarded immediately, with no partial output.
- `in_ready` has no combinational dependence on `in_valid`.
- `out_valid` is registered only.

## Structure
- Package `fma_pkg`:
  - `WIDTH`, `EXP_W` and `LZC_W` constants.
  - An `S1` payload struct with fields `sum`, `cout`, `exp`, `sticky` and `lzc`.
- Sub-module `fma_lzc`: combinational leading-zero counter.
  - Input: WIDTH bits. Output: LZC_W bits.
  - Implemented as a tree of 4-bit leading-zero-count cells, mirroring the adder's 4-bit grouping.
  - Output = WIDTH for an all-zero input.
- The S2 shifter is a log-depth barrel shifter, inline in `fma_normalizer`.

## Test plan
- **MSB set**: `in_sum` = 1<<105, `cout` = 0, `exp` = 10 → after 2 cycles: `out_mant` = 1<<105, `out_exp` = 10, `out_zero` = 0.
- **LSB only**: `in_sum` = 1, `exp` = 0 → `out_mant` = 1<<105, `out_exp` = −105, sticky passes through.
- **Carry with dropped bit**: `cout` = 1, `in_sum` = 1, `exp` = 5, `sticky` = 0 → `out_mant` = 1<<105, `out_exp` = 6, `out_sticky` = 1.
- **Zero**: `cout` = 0, `in_sum` = 0, `sticky` = 1 → `out_zero` = 1, `out_mant` = 0, `out_exp` = 0, `out_sticky` = 1.
- **Backpressure**: send beats A, B, C back-to-back with `out_ready` = 0 → `in_ready` = 0 once A and B are held, with C waiting. Then set `out_ready` = 1 → outputs A, B, C in order on consecutive cycles, with A held stable throughout the stall.
- **Reset mid-flight**: assert `rst` with 2 beats in flight → `out_valid` = 0 on the same edge or asynchronously. After release, `in_ready` = 1 and no stale beat appears.
